// File: rtl/bnn_layer_sequencer_if.sv
// Handshake and configuration bundle between the inference controller and
// the layer sequencer. The master drives start/abort/write-back/result
// strobes; the slave (the sequencer) drives the datapath configuration.
interface bnn_layer_sequencer_if;
  logic       iSTART;
  logic       iABORT;
  logic       iWR_PULSE;
  logic       iFINAL_VALID;
  logic [3:0] iFINAL_CLASS;

  logic [2:0] oLAYER;
  logic       oLAYER_START;
  logic       oFLUSH;
  logic [3:0] oACC_MV;
  logic [8:0] oTH_BASE;
  logic [8:0] oRD_BASE;
  logic [8:0] oWR_ADDR;
  logic       oBUSY;
  logic       oDONE;
  logic [3:0] oCLASS;
  logic       oERR;

  modport master (
    output iSTART, iABORT, iWR_PULSE, iFINAL_VALID, iFINAL_CLASS,
    input  oLAYER, oLAYER_START, oFLUSH, oACC_MV, oTH_BASE, oRD_BASE,
           oWR_ADDR, oBUSY, oDONE, oCLASS, oERR
  );

  modport slave (
    input  iSTART, iABORT, iWR_PULSE, iFINAL_VALID, iFINAL_CLASS,
    output oLAYER, oLAYER_START, oFLUSH, oACC_MV, oTH_BASE, oRD_BASE,
           oWR_ADDR, oBUSY, oDONE, oCLASS, oERR
  );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// Layer scheduler for the binarized CNN pipeline. Walks the shared datapath
// through CONV1, CONV2, CONV3, FCL1 and FCL2, supplies the per-layer
// configuration, counts write-back strobes to detect layer completion,
// issues a one-cycle flush between layers and latches the final class.
// Optional per-layer watchdog: define BNN_WATCHDOG_EN to enable it.
module bnn_layer_sequencer #(
  parameter logic [8:0]  MEM1_OFFSET    = 9'd252,
  parameter logic [8:0]  TH_STRIDE      = 9'd112,
  parameter logic [8:0]  CONV1_WR       = 9'd252,
  parameter logic [8:0]  CONV2_WR       = 9'd48,
  parameter logic [8:0]  CONV3_WR       = 9'd6,
  parameter logic [8:0]  FCL1_WR        = 9'd1,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input logic                  iCLK,
  input logic                  iRST,
  bnn_layer_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_FLUSH,
    S_FINAL
`ifdef BNN_WATCHDOG_EN
    ,
    S_ERR
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] l_q, l_d;
  logic [8:0] w_q, w_d;
  logic [3:0] class_q, class_d;
  logic       done_q, done_d;

  logic [2:0] layer_q, layer_d;
  logic       layer_start_q, layer_start_d;
  logic       flush_q, flush_d;
  logic [3:0] acc_mv_q, acc_mv_d;
  logic [8:0] th_base_q, th_base_d;
  logic [8:0] rd_base_q, rd_base_d;
  logic [8:0] wr_addr_q, wr_addr_d;
  logic       busy_q, busy_d;
  logic [8:0] wr_base;
  logic [8:0] target;

`ifdef BNN_WATCHDOG_EN
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
  logic        timeout;
`endif

  // Write-back count that ends the current layer (FCL2 never reaches RUN)
  always_comb begin
    case (l_q)
      3'd0:    target = CONV1_WR;
      3'd1:    target = CONV2_WR;
      3'd2:    target = CONV3_WR;
      default: target = FCL1_WR;
    endcase
  end

`ifdef BNN_WATCHDOG_EN
  // Cycle counter cleared at every layer start and every write-back strobe
  always_comb begin
    timeout = (wd_q >= (TIMEOUT_CYCLES - 16'd1));
    if ((state_d == S_START) || bus.iWR_PULSE) begin
      wd_d = 16'd0;
    end else if (wd_q == 16'hFFFF) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + 16'd1;
    end
  end
`endif

  // Next-state, layer index, write count and result latch
  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    w_d     = w_q;
    class_d = class_q;
    done_d  = 1'b0;
    if (bus.iABORT) begin
      state_d = S_IDLE;
      l_d     = 3'd0;
      w_d     = 9'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.iSTART) begin
            state_d = S_START;
            l_d     = 3'd0;
            w_d     = 9'd0;
          end
        end
        S_START: begin
          w_d     = 9'd0;
          state_d = (l_q == 3'd4) ? S_FINAL : S_RUN;
        end
        S_RUN: begin
          if (bus.iWR_PULSE) begin
            if (w_q != target) begin
              w_d = w_q + 9'd1;
            end
            if (w_d == target) begin
              state_d = S_FLUSH;
            end
          end
`ifdef BNN_WATCHDOG_EN
          else if (timeout) begin
            state_d = S_ERR;
          end
`endif
        end
        S_FLUSH: begin
          l_d     = l_q + 3'd1;
          w_d     = 9'd0;
          state_d = S_START;
        end
        S_FINAL: begin
          if (bus.iFINAL_VALID) begin
            class_d = bus.iFINAL_CLASS;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
`ifdef BNN_WATCHDOG_EN
          else if (timeout) begin
            state_d = S_ERR;
          end
`endif
        end
`ifdef BNN_WATCHDOG_EN
        S_ERR: begin
          state_d = S_ERR;
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Registered outputs derived from the upcoming state and layer
  always_comb begin
    layer_d   = 3'b000;
    acc_mv_d  = 4'd9;
    th_base_d = 9'd0;
    rd_base_d = 9'd0;
    wr_base   = 9'd0;
    wr_addr_d = 9'd0;
    if (state_d != S_IDLE) begin
      case (l_d)
        3'd0: begin
          layer_d = 3'b010;
        end
        3'd1: begin
          layer_d   = 3'b011;
          th_base_d = TH_STRIDE;
          wr_base   = MEM1_OFFSET;
        end
        3'd2: begin
          layer_d   = 3'b100;
          th_base_d = TH_STRIDE * 9'd2;
          rd_base_d = MEM1_OFFSET;
        end
        3'd3: begin
          layer_d   = 3'b101;
          acc_mv_d  = 4'd6;
          th_base_d = TH_STRIDE * 9'd3;
          wr_base   = MEM1_OFFSET;
        end
        default: begin
          layer_d   = 3'b110;
          acc_mv_d  = 4'd6;
          rd_base_d = MEM1_OFFSET;
        end
      endcase
      wr_addr_d = wr_base + w_d;
    end
    layer_start_d = (state_d == S_START);
    busy_d        = (state_d != S_IDLE);
`ifdef BNN_WATCHDOG_EN
    flush_d = (state_d == S_FLUSH) || ((state_d == S_ERR) && (state_q != S_ERR));
    err_d   = (state_d == S_ERR);
`else
    flush_d = (state_d == S_FLUSH);
`endif
  end

  // State and output registers with synchronous reset
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q       <= S_IDLE;
      l_q           <= 3'd0;
      w_q           <= 9'd0;
      class_q       <= 4'd0;
      done_q        <= 1'b0;
      layer_q       <= 3'b000;
      layer_start_q <= 1'b0;
      flush_q       <= 1'b0;
      acc_mv_q      <= 4'd9;
      th_base_q     <= 9'd0;
      rd_base_q     <= 9'd0;
      wr_addr_q     <= 9'd0;
      busy_q        <= 1'b0;
`ifdef BNN_WATCHDOG_EN
      wd_q          <= 16'd0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      l_q           <= l_d;
      w_q           <= w_d;
      class_q       <= class_d;
      done_q        <= done_d;
      layer_q       <= layer_d;
      layer_start_q <= layer_start_d;
      flush_q       <= flush_d;
      acc_mv_q      <= acc_mv_d;
      th_base_q     <= th_base_d;
      rd_base_q     <= rd_base_d;
      wr_addr_q     <= wr_addr_d;
      busy_q        <= busy_d;
`ifdef BNN_WATCHDOG_EN
      wd_q          <= wd_d;
      err_q         <= err_d;
`endif
    end
  end

  assign bus.oLAYER       = layer_q;
  assign bus.oLAYER_START = layer_start_q;
  assign bus.oFLUSH       = flush_q;
  assign bus.oACC_MV      = acc_mv_q;
  assign bus.oTH_BASE     = th_base_q;
  assign bus.oRD_BASE     = rd_base_q;
  assign bus.oWR_ADDR     = wr_addr_q;
  assign bus.oBUSY        = busy_q;
  assign bus.oDONE        = done_q;
  assign bus.oCLASS       = class_q;
`ifdef BNN_WATCHDOG_EN
  assign bus.oERR         = err_q;
`else
  assign bus.oERR         = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed self-checking bench for bnn_layer_sequencer (default build).
module tb_bnn_layer_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   flushCount = 0;
   int   doneCount = 0;

   bnn_layer_sequencer_if bus ();

   bnn_layer_sequencer dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Count flush and done pulses away from the active edge
   always @(negedge clk) begin
      if (bus.oFLUSH === 1'b1) flushCount++;
      if (bus.oDONE === 1'b1) doneCount++;
   end

   // Advance a number of cycles and settle just after the edge
   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Hold the write-back strobe high for n consecutive cycles
   task automatic pulses(input int n);
      bus.iWR_PULSE = 1'b1;
      applyStimulus(n);
      bus.iWR_PULSE = 1'b0;
   endtask

   // Finish a layer from RUN and step through FLUSH and START
   task automatic runLayer(input int n);
      pulses(n);
      applyStimulus(2);
   endtask

   // Check every output against its reset value
   task automatic checkResetOutputs(input string tag, input logic [3:0] expClass);
      checkOutput({tag, " layer"}, 16'(bus.oLAYER), 16'd0);
      checkOutput({tag, " layer_start"}, 16'(bus.oLAYER_START), 16'd0);
      checkOutput({tag, " flush"}, 16'(bus.oFLUSH), 16'd0);
      checkOutput({tag, " acc_mv"}, 16'(bus.oACC_MV), 16'd9);
      checkOutput({tag, " th_base"}, 16'(bus.oTH_BASE), 16'd0);
      checkOutput({tag, " rd_base"}, 16'(bus.oRD_BASE), 16'd0);
      checkOutput({tag, " wr_addr"}, 16'(bus.oWR_ADDR), 16'd0);
      checkOutput({tag, " busy"}, 16'(bus.oBUSY), 16'd0);
      checkOutput({tag, " done"}, 16'(bus.oDONE), 16'd0);
      checkOutput({tag, " class"}, 16'(bus.oCLASS), 16'(expClass));
      checkOutput({tag, " err"}, 16'(bus.oERR), 16'd0);
   endtask

   // Linear directed sequence covering full run, abort and reset cases
   initial begin
      bus.iSTART       = 1'b0;
      bus.iABORT       = 1'b0;
      bus.iWR_PULSE    = 1'b0;
      bus.iFINAL_VALID = 1'b0;
      bus.iFINAL_CLASS = 4'd0;

      applyStimulus(2);
      checkResetOutputs("reset", 4'd0);
      rst = 1'b0;

      bus.iWR_PULSE    = 1'b1;
      bus.iFINAL_VALID = 1'b1;
      bus.iFINAL_CLASS = 4'd3;
      applyStimulus(1);
      bus.iWR_PULSE    = 1'b0;
      bus.iFINAL_VALID = 1'b0;
      checkOutput("idle_ignore busy", 16'(bus.oBUSY), 16'd0);
      checkOutput("idle_ignore class", 16'(bus.oCLASS), 16'd0);
      checkOutput("idle_ignore wr_addr", 16'(bus.oWR_ADDR), 16'd0);

      bus.iSTART = 1'b1;
      applyStimulus(1);
      bus.iSTART = 1'b0;
      checkOutput("start layer_start", 16'(bus.oLAYER_START), 16'd1);
      checkOutput("start layer", 16'(bus.oLAYER), 16'd2);
      checkOutput("start busy", 16'(bus.oBUSY), 16'd1);

      pulses(1);
      checkOutput("pulse_in_start wr_addr", 16'(bus.oWR_ADDR), 16'd0);
      checkOutput("run layer_start", 16'(bus.oLAYER_START), 16'd0);

      bus.iSTART = 1'b1;
      applyStimulus(1);
      bus.iSTART = 1'b0;
      checkOutput("start_in_run layer_start", 16'(bus.oLAYER_START), 16'd0);
      checkOutput("start_in_run layer", 16'(bus.oLAYER), 16'd2);

      pulses(251);
      checkOutput("conv1 wr_addr 251", 16'(bus.oWR_ADDR), 16'd251);
      checkOutput("conv1 no early flush", 16'(bus.oFLUSH), 16'd0);

      bus.iWR_PULSE = 1'b1;
      applyStimulus(1);
      checkOutput("conv1 flush", 16'(bus.oFLUSH), 16'd1);
      checkOutput("conv1 wr_addr 252", 16'(bus.oWR_ADDR), 16'd252);
      applyStimulus(1);
      checkOutput("conv2 layer", 16'(bus.oLAYER), 16'd3);
      checkOutput("conv2 layer_start", 16'(bus.oLAYER_START), 16'd1);
      checkOutput("conv2 flush low", 16'(bus.oFLUSH), 16'd0);
      checkOutput("conv2 wr_addr", 16'(bus.oWR_ADDR), 16'd252);
      checkOutput("conv2 rd_base", 16'(bus.oRD_BASE), 16'd0);
      checkOutput("conv2 th_base", 16'(bus.oTH_BASE), 16'd112);
      checkOutput("conv2 acc_mv", 16'(bus.oACC_MV), 16'd9);
      applyStimulus(1);
      bus.iWR_PULSE = 1'b0;
      checkOutput("conv2 run wr_addr", 16'(bus.oWR_ADDR), 16'd252);

      pulses(47);
      checkOutput("conv2 wr_addr 299", 16'(bus.oWR_ADDR), 16'd299);
      pulses(1);
      checkOutput("conv2 flush", 16'(bus.oFLUSH), 16'd1);

      applyStimulus(1);
      checkOutput("conv3 layer", 16'(bus.oLAYER), 16'd4);
      checkOutput("conv3 th_base", 16'(bus.oTH_BASE), 16'd224);
      checkOutput("conv3 rd_base", 16'(bus.oRD_BASE), 16'd252);
      checkOutput("conv3 wr_addr", 16'(bus.oWR_ADDR), 16'd0);
      applyStimulus(1);
      pulses(5);
      checkOutput("conv3 wr_addr 5", 16'(bus.oWR_ADDR), 16'd5);
      checkOutput("conv3 no early flush", 16'(bus.oFLUSH), 16'd0);
      pulses(1);
      checkOutput("conv3 flush", 16'(bus.oFLUSH), 16'd1);

      applyStimulus(1);
      checkOutput("fcl1 layer", 16'(bus.oLAYER), 16'd5);
      checkOutput("fcl1 th_base", 16'(bus.oTH_BASE), 16'd336);
      checkOutput("fcl1 acc_mv", 16'(bus.oACC_MV), 16'd6);
      checkOutput("fcl1 rd_base", 16'(bus.oRD_BASE), 16'd0);
      checkOutput("fcl1 wr_addr", 16'(bus.oWR_ADDR), 16'd252);
      checkOutput("fcl1 layer_start", 16'(bus.oLAYER_START), 16'd1);
      applyStimulus(1);
      pulses(1);
      checkOutput("fcl1 flush", 16'(bus.oFLUSH), 16'd1);
      checkOutput("fcl1 wr_addr 253", 16'(bus.oWR_ADDR), 16'd253);

      applyStimulus(1);
      checkOutput("fcl2 layer", 16'(bus.oLAYER), 16'd6);
      checkOutput("fcl2 acc_mv", 16'(bus.oACC_MV), 16'd6);
      checkOutput("fcl2 th_base", 16'(bus.oTH_BASE), 16'd0);
      checkOutput("fcl2 rd_base", 16'(bus.oRD_BASE), 16'd252);
      checkOutput("fcl2 wr_addr", 16'(bus.oWR_ADDR), 16'd0);
      checkOutput("fcl2 layer_start", 16'(bus.oLAYER_START), 16'd1);
      applyStimulus(1);
      checkOutput("final busy", 16'(bus.oBUSY), 16'd1);
      checkOutput("final layer", 16'(bus.oLAYER), 16'd6);
      pulses(1);
      checkOutput("final pulse wr_addr", 16'(bus.oWR_ADDR), 16'd0);
      checkOutput("final pulse flush", 16'(bus.oFLUSH), 16'd0);

      bus.iFINAL_VALID = 1'b1;
      bus.iFINAL_CLASS = 4'd7;
      applyStimulus(1);
      bus.iFINAL_VALID = 1'b0;
      checkOutput("done pulse", 16'(bus.oDONE), 16'd1);
      checkOutput("done class", 16'(bus.oCLASS), 16'd7);
      checkOutput("done busy", 16'(bus.oBUSY), 16'd0);
      checkOutput("done layer", 16'(bus.oLAYER), 16'd0);

      bus.iSTART = 1'b1;
      applyStimulus(1);
      bus.iSTART = 1'b0;
      checkOutput("restart done low", 16'(bus.oDONE), 16'd0);
      checkOutput("restart layer_start", 16'(bus.oLAYER_START), 16'd1);
      checkOutput("restart layer", 16'(bus.oLAYER), 16'd2);
      checkOutput("restart class", 16'(bus.oCLASS), 16'd7);
      checkOutput("flush count", 16'(flushCount), 16'd4);
      checkOutput("done count", 16'(doneCount), 16'd1);

      applyStimulus(1);
      runLayer(252);
      runLayer(48);
      checkOutput("abort_run conv3 layer", 16'(bus.oLAYER), 16'd4);
      pulses(3);
      checkOutput("abort_run conv3 wr_addr", 16'(bus.oWR_ADDR), 16'd3);
      bus.iABORT = 1'b1;
      applyStimulus(1);
      bus.iABORT = 1'b0;
      checkResetOutputs("abort", 4'd7);

      bus.iSTART = 1'b1;
      applyStimulus(1);
      bus.iSTART = 1'b0;
      checkOutput("post_abort layer", 16'(bus.oLAYER), 16'd2);
      checkOutput("post_abort layer_start", 16'(bus.oLAYER_START), 16'd1);
      checkOutput("post_abort wr_addr", 16'(bus.oWR_ADDR), 16'd0);
      applyStimulus(1);
      pulses(1);
      checkOutput("post_abort wr_addr 1", 16'(bus.oWR_ADDR), 16'd1);

      runLayer(251);
      runLayer(48);
      runLayer(6);
      runLayer(1);
      checkOutput("reset_run final busy", 16'(bus.oBUSY), 16'd1);
      checkOutput("reset_run final layer", 16'(bus.oLAYER), 16'd6);
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
      checkResetOutputs("reset_in_final", 4'd0);

      bus.iFINAL_VALID = 1'b1;
      bus.iFINAL_CLASS = 4'd5;
      applyStimulus(1);
      bus.iFINAL_VALID = 1'b0;
      checkOutput("post_reset done", 16'(bus.oDONE), 16'd0);
      checkOutput("post_reset class", 16'(bus.oCLASS), 16'd0);
      checkOutput("post_reset busy", 16'(bus.oBUSY), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bnn_layer_sequencer.md
# bnn_layer_sequencer

Top-level layer scheduler for the binarized CNN pipeline. Steps the shared XNOR-popcount / accumulator / comparator / maxpooling datapath through CONV1, CONV2, CONV3, FCL1 and FCL2. For each layer it supplies the datapath configuration: layer code, accumulate depth, threshold ROM base, and MEM1 ping-pong read/write bases. It counts write-back strobes to detect layer completion, issues a one-cycle datapath flush between layers, and latches the final class index.

## Interface
Parameters:
- MEM1_OFFSET, 252, MEM1 ping-pong bank base
- TH_STRIDE, 112, threshold ROM words per layer
- CONV1_WR, 252, MEM1 writes ending CONV1
- CONV2_WR, 48, MEM1 writes ending CONV2
- CONV3_WR, 6, MEM1 writes ending CONV3
- FCL1_WR, 1, MEM1 writes ending FCL1
- TIMEOUT_CYCLES, 16'd65535, per-layer watchdog limit (used only with BNN_WATCHDOG_EN)

Ports:
- iCLK  in  1  clock
- iRST  in  1  synchronous active-high reset
- iSTART  in  1  start inference (sampled in IDLE only)
- iABORT  in  1  abandon inference, return to IDLE
- iWR_PULSE  in  1  one MEM1 write-back strobe from the maxpooling stage
- iFINAL_VALID  in  1  FCL2 result valid strobe
- iFINAL_CLASS  in  4  FCL2 argmax index
- oLAYER  out  3  layer code: IDLE 3'b000, CONV1 010, CONV2 011, CONV3 100, FCL1 101, FCL2 110
- oLAYER_START  out  1  one-cycle pulse at the start of each layer
- oFLUSH  out  1  one-cycle datapath clear, issued after each layer
- oACC_MV  out  4  accumulator max count
- oTH_BASE  out  9  threshold ROM base
- oRD_BASE  out  9  MEM1 read base
- oWR_ADDR  out  9  MEM1 write address for the next write
- oBUSY  out  1  high outside IDLE
- oDONE  out  1  one-cycle completion pulse
- oCLASS  out  4  latched result
- oERR  out  1  sticky watchdog error (always 0 without the macro)

## Operation
- States: IDLE, START, RUN, FLUSH, FINAL, ERR. ERR exists only with the macro.
- Internal counters:
  - layer index L, 0..4 (CONV1..FCL2)
  - write count W, 9 bit
- IDLE:
  - iSTART=1 → START with L=0.
  - iWR_PULSE and iFINAL_VALID are ignored.
- START:
  - oLAYER_START=1 and W=0.
  - Next state: RUN if L≤3, FINAL if L=4.
- RUN:
  - Each iWR_PULSE increments W.
  - When the pulse makes W equal to the layer target (CONV1_WR, CONV2_WR, CONV3_WR or FCL1_WR), next state is FLUSH.
  - W holds at the target.
- FLUSH:
  - oFLUSH=1 for exactly one cycle.
  - L increments, then START.
- FINAL:
  - iFINAL_VALID=1 latches iFINAL_CLASS into oCLASS.
  - oDONE pulses in the same transition, then IDLE.
- Per-layer configuration, valid from START through FLUSH:
  - oACC_MV: 9 for CONV layers, 6 for FCL layers.
  - oTH_BASE = L·TH_STRIDE for L≤3, 0 for FCL2.
  - oRD_BASE: CONV1 0 (MEM0 is used), CONV2 0, CONV3 MEM1_OFFSET, FCL1 0, FCL2 MEM1_OFFSET.
  - Write base: CONV1 0, CONV2 MEM1_OFFSET, CONV3 0, FCL1 MEM1_OFFSET, FCL2 0.
  - oWR_ADDR = write base + W, computed in 9-bit arithmetic; 252+47=299 fits.
- Priority: iRST > iABORT > normal transitions.
- iABORT in any state → IDLE next cycle. All outputs take their reset values except oCLASS, which holds.
- iSTART outside IDLE is ignored.
- iWR_PULSE in START, FLUSH or FINAL is ignored and not counted.

## Timing
- All outputs are registered.
- Reset values: oLAYER=000, oLAYER_START=0, oFLUSH=0, oACC_MV=9, oTH_BASE=0, oRD_BASE=0, oWR_ADDR=0, oBUSY=0, oDONE=0, oCLASS=0, oERR=0.
- iSTART at edge n:
  - oLAYER_START=1 and oLAYER=010 at n+1.
  - RUN from n+2.
- Final iWR_PULSE of a layer at edge m:
  - oFLUSH=1 at m+1.
  - Next layer's oLAYER_START at m+2, with the new oLAYER and new bases that same cycle.
- iWR_PULSE in the cycle where W reaches the target is the last one counted.
- iFINAL_VALID at edge k: oDONE=1 and oCLASS valid at k+1; oBUSY=0 at k+1.
- A new iSTART in the cycle after oDONE is accepted.
- Minimum layer overhead: 2 cycles (FLUSH + START).

## Configuration
- BNN_WATCHDOG_EN defined:
  - A 16-bit cycle counter clears on every oLAYER_START and on every iWR_PULSE.
  - Reaching TIMEOUT_CYCLES in RUN or FINAL → ERR. In ERR: oERR=1, oBUSY=1, oFLUSH=1 for one cycle on entry.
  - ERR exits only on iABORT or iRST. iABORT clears oERR.
- BNN_WATCHDOG_EN undefined: no counter, no ERR state, oERR tied 0.

## Test plan
- Full run: iSTART, then 252/48/6/1 iWR_PULSE per layer, then iFINAL_VALID with class 7 → oLAYER sequence 010,011,100,101,110; four oFLUSH pulses; oDONE=1 once; oCLASS=7; oBUSY=0.
- Address check: in CONV2, 48 pulses → oWR_ADDR runs 252..299, oRD_BASE=0, oTH_BASE=112. In FCL1, oWR_ADDR=252, oTH_BASE=336, oACC_MV=6.
- Ignored inputs: iWR_PULSE during FLUSH/START and iSTART during RUN → W unchanged, no restart; CONV1 still needs exactly 252 counted pulses.
- iABORT mid-CONV3 (W=3) → IDLE next cycle with outputs at reset values except oCLASS; the next iSTART restarts at CONV1 with W=0.
- iRST asserted during FINAL → all outputs at reset values next cycle, oCLASS=0; a following iFINAL_VALID has no effect.
- With BNN_WATCHDOG_EN and TIMEOUT_CYCLES=20: stall with no pulses → oERR=1 after 20 cycles, one oFLUSH pulse; iABORT → IDLE with oERR=0.
